// File: rtl/fir_mac_array_serial.sv
// Run-time-programmable serial FIR: MAC_NUM parallel MACs each walk TAPS_PER_MAC taps, pipelined adder tree.
// Optional output saturation with sticky ovf enabled by macro FIR_MAC_ARRAY_SAT_EN.
module fir_mac_array_serial #(
  parameter int unsigned DIN_BITS     = 16,
  parameter int unsigned COEFF_BITS   = 16,
  parameter int unsigned MAC_NUM      = 2,
  parameter int unsigned TAPS_PER_MAC = 4,
  parameter int unsigned DOUT_BITS    = 16,
  parameter int unsigned OUT_SHIFT    = 15
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          clken,
  input  logic                                          coeff_wr,
  input  logic [$clog2(MAC_NUM*TAPS_PER_MAC)-1:0]       coeff_addr,
  input  logic [COEFF_BITS-1:0]                         coeff_data,
  output logic                                          coeff_ready,
  input  logic                                          din_valid,
  input  logic [DIN_BITS-1:0]                           din,
  output logic                                          din_ready,
  output logic [DOUT_BITS-1:0]                          dout,
  output logic                                          dout_valid,
  output logic                                          ovf
);

  localparam int unsigned TAPS      = MAC_NUM * TAPS_PER_MAC;
  localparam int unsigned ADDR_BITS = $clog2(TAPS);
  localparam int unsigned KW        = $clog2(TAPS_PER_MAC);
  localparam int unsigned ADD_ST    = $clog2(MAC_NUM);
  localparam int unsigned PROD_BITS = DIN_BITS + COEFF_BITS;
  localparam int unsigned ACC_BITS  = DIN_BITS + COEFF_BITS + $clog2(TAPS);
  localparam int unsigned RW        = ACC_BITS + 1;
  localparam logic signed [RW-1:0] RND = RW'((RW'(1) << OUT_SHIFT) >> 1);

  typedef enum logic {ST_IDLE, ST_MAC} state_t;

  state_t                       state_q, state_d;
  logic [KW-1:0]                k_q, k_d;
  logic                         accept_c, last_c;
  logic signed [DIN_BITS-1:0]   x_q     [TAPS];
  logic signed [COEFF_BITS-1:0] coeff_q [TAPS];
  logic signed [ACC_BITS-1:0]   acc_q   [MAC_NUM];
  logic signed [PROD_BITS-1:0]  prod_c  [MAC_NUM];
  logic signed [ACC_BITS-1:0]   part_c  [MAC_NUM];
  logic signed [ACC_BITS-1:0]   sum_c;
  logic                         sum_vld_c;
  logic signed [RW-1:0]         rnd_c;
  logic [DOUT_BITS-1:0]         dout_q;
  logic                         dout_valid_q;

  assign din_ready   = (state_q == ST_IDLE);
  assign coeff_ready = (state_q == ST_IDLE);

  // Next-state: one accept, then TAPS_PER_MAC MAC cycles
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    accept_c = 1'b0;
    last_c   = 1'b0;
    if (clken) begin
      case (state_q)
        ST_IDLE: begin
          if (din_valid) begin
            accept_c = 1'b1;
            state_d  = ST_MAC;
            k_d      = '0;
          end
        end
        ST_MAC: begin
          if (k_q == KW'(TAPS_PER_MAC - 1)) begin
            last_c  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Per-MAC product and running sum; part_c is the final partial at the last tap
  always_comb begin
    for (int m = 0; m < MAC_NUM; m++) begin
      prod_c[m] = PROD_BITS'(coeff_q[ADDR_BITS'(m * TAPS_PER_MAC) + ADDR_BITS'(k_q)])
                * PROD_BITS'(x_q[ADDR_BITS'(m * TAPS_PER_MAC) + ADDR_BITS'(k_q)]);
      part_c[m] = ((k_q == '0) ? '0 : acc_q[m]) + ACC_BITS'(prod_c[m]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      for (int i = 0; i < TAPS; i++) begin
        x_q[i]     <= '0;
        coeff_q[i] <= '0;
      end
      for (int m = 0; m < MAC_NUM; m++) acc_q[m] <= '0;
    end else if (clken) begin
      state_q <= state_d;
      k_q     <= k_d;
      if (coeff_wr && coeff_ready && (int'(coeff_addr) < TAPS))
        coeff_q[coeff_addr] <= coeff_data;
      if (accept_c) begin
        x_q[0] <= din;
        for (int i = 1; i < TAPS; i++) x_q[i] <= x_q[i-1];
      end
      if (state_q == ST_MAC)
        for (int m = 0; m < MAC_NUM; m++) acc_q[m] <= part_c[m];
    end
  end

  // Binary adder tree, one register per level
  if (ADD_ST == 0) begin : g_flat
    assign sum_c     = part_c[0];
    assign sum_vld_c = last_c;
  end else begin : g_tree
    localparam int unsigned HALF = MAC_NUM / 2;
    logic signed [ACC_BITS-1:0] lvl_c [ADD_ST+1][MAC_NUM];
    logic signed [ACC_BITS-1:0] stg_q [ADD_ST][HALF];
    logic [ADD_ST-1:0]          vld_q;

    always_comb begin
      for (int s = 0; s <= ADD_ST; s++)
        for (int j = 0; j < MAC_NUM; j++) lvl_c[s][j] = '0;
      for (int j = 0; j < MAC_NUM; j++) lvl_c[0][j] = part_c[j];
      for (int s = 0; s < ADD_ST; s++)
        for (int j = 0; j < HALF; j++) lvl_c[s+1][j] = stg_q[s][j];
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld_q <= '0;
        for (int s = 0; s < ADD_ST; s++)
          for (int j = 0; j < HALF; j++) stg_q[s][j] <= '0;
      end else if (clken) begin
        vld_q <= (vld_q << 1) | ADD_ST'(last_c);
        for (int s = 0; s < ADD_ST; s++)
          for (int j = 0; j < HALF; j++) stg_q[s][j] <= lvl_c[s][2*j] + lvl_c[s][2*j+1];
      end
    end

    assign sum_c     = lvl_c[ADD_ST][0];
    assign sum_vld_c = vld_q[ADD_ST-1];
  end

  assign rnd_c = RW'(sum_c) + RND;

`ifdef FIR_MAC_ARRAY_SAT_EN
  localparam logic [DOUT_BITS-1:0] DMAX = {1'b0, {(DOUT_BITS-1){1'b1}}};
  localparam logic [DOUT_BITS-1:0] DMIN = {1'b1, {(DOUT_BITS-1){1'b0}}};
  logic signed [RW-1:0]     shf_c;
  logic [RW-DOUT_BITS:0]    hi_c;
  logic                     ovr_c;
  logic                     ovf_q;

  assign shf_c = rnd_c >>> OUT_SHIFT;
  assign hi_c  = shf_c[RW-1:DOUT_BITS-1];
  // Out of range whenever the bits above the output sign are not a pure sign extension
  assign ovr_c = ~((&hi_c) | ~(|hi_c));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else if (clken) begin
      dout_valid_q <= sum_vld_c;
      if (sum_vld_c) begin
        dout_q <= ovr_c ? (shf_c[RW-1] ? DMIN : DMAX) : shf_c[DOUT_BITS-1:0];
        ovf_q  <= ovf_q | ovr_c;
      end
    end
  end

  assign ovf = ovf_q;
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else if (clken) begin
      dout_valid_q <= sum_vld_c;
      if (sum_vld_c) dout_q <= DOUT_BITS'(rnd_c >>> OUT_SHIFT);
    end
  end

  assign ovf = 1'b0;
`endif

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_fir_mac_array_serial.sv
// Directed bench for fir_mac_array_serial (MAC_NUM=2, TAPS_PER_MAC=4, DOUT_BITS=16, OUT_SHIFT=2).
// Expected values are hand-computed; the saturation case follows FIR_MAC_ARRAY_SAT_EN.
module tb_fir_mac_array_serial;

  logic        clk;
  logic        reset;
  logic        clken;
  logic        coeff_wr;
  logic [2:0]  coeff_addr;
  logic [15:0] coeff_data;
  logic        coeff_ready;
  logic        din_valid;
  logic [15:0] din;
  logic        din_ready;
  logic [15:0] dout;
  logic        dout_valid;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  fir_mac_array_serial #(
    .DIN_BITS(16), .COEFF_BITS(16), .MAC_NUM(2), .TAPS_PER_MAC(4),
    .DOUT_BITS(16), .OUT_SHIFT(2)
  ) dut (
    .clk(clk), .reset(reset), .clken(clken),
    .coeff_wr(coeff_wr), .coeff_addr(coeff_addr), .coeff_data(coeff_data),
    .coeff_ready(coeff_ready),
    .din_valid(din_valid), .din(din), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic write_coeff(input int addr, input logic [15:0] val);
    coeff_wr   = 1'b1;
    coeff_addr = 3'(addr);
    coeff_data = val;
    tick();
    coeff_wr   = 1'b0;
  endtask

  // n counts cycles since the accept; dout_valid must drop on the following cycle
  task automatic wait_out(input string tag, input int start, output int lat, output logic [15:0] val);
    int n;
    n = start;
    while (!dout_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, 64'(n < 40), 64'(1));
    lat = n;
    val = dout;
    tick();
    chk({tag, "_pulse"}, 64'(dout_valid), 64'(0));
  endtask

  task automatic send(input string tag, input logic [15:0] v, input logic [15:0] exp);
    int          lat;
    logic [15:0] val;
    din       = v;
    din_valid = 1'b1;
    chk({tag, "_rdy"}, 64'(din_ready), 64'(1));
    tick();
    din_valid = 1'b0;
    wait_out(tag, 1, lat, val);
    chk({tag, "_dout"}, 64'(val), 64'(exp));
    chk({tag, "_lat"}, 64'(lat), 64'(6));
  endtask

  initial begin
    int          lat;
    int          got;
    int          cnt;
    logic [15:0] val;
    logic [15:0] t2_exp [3];
    logic [15:0] t4_exp [8];

    reset = 1'b1; clken = 1'b1; coeff_wr = 1'b0; coeff_addr = '0; coeff_data = '0;
    din_valid = 1'b0; din = '0;
    tick();
    tick();
    chk("rst_dout", 64'(dout), 64'(0));
    chk("rst_dout_valid", 64'(dout_valid), 64'(0));
    chk("rst_ovf", 64'(ovf), 64'(0));
    chk("rst_din_ready", 64'(din_ready), 64'(1));
    chk("rst_coeff_ready", 64'(coeff_ready), 64'(1));
    reset = 1'b0;
    tick();

    // T1 impulse: coeff[i]=4*(i+1) so the shift by 2 yields i+1 exactly
    for (int i = 0; i < 8; i++) write_coeff(i, 16'(4 * (i + 1)));
    send("t1_0", 16'd1, 16'd1);
    for (int i = 1; i < 8; i++) send($sformatf("t1_%0d", i), 16'd0, 16'(i + 1));

    // T2 backpressure: only coeff[0]=4 so each output equals its accepted sample
    pulse_reset();
    write_coeff(0, 16'd4);
    t2_exp = '{16'd100, 16'd105, 16'd110};
    got = 0;
    for (int c = 0; c < 20; c++) begin
      din_valid = (c < 15);
      din       = 16'(100 + c);
      if (c < 15) chk($sformatf("t2_rdy_%0d", c), 64'(din_ready), 64'((c % 5) == 0));
      if (dout_valid) begin
        if (got < 3) chk($sformatf("t2_out_%0d", got), 64'(dout), 64'(t2_exp[got]));
        got++;
      end
      tick();
    end
    din_valid = 1'b0;
    chk("t2_count", 64'(got), 64'(3));

    // T3 rounding, half up, including a negative sum
    pulse_reset();
    for (int i = 0; i < 8; i++) write_coeff(i, 16'd1);
    send("t3_a", 16'd3, 16'd1);
    send("t3_b", 16'd6, 16'd2);
    send("t3_neg", 16'hFFEC, 16'hFFFD);

    // T4 full-scale: 0x7FFF coefficients and samples
    pulse_reset();
    chk("t4_ovf_pre", 64'(ovf), 64'(0));
    for (int i = 0; i < 8; i++) write_coeff(i, 16'h7FFF);
`ifdef FIR_MAC_ARRAY_SAT_EN
    t4_exp = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
`else
    t4_exp = '{16'hC000, 16'h8001, 16'h4001, 16'h0001, 16'hC001, 16'h8002, 16'h4002, 16'h0002};
`endif
    for (int i = 0; i < 8; i++) send($sformatf("t4_%0d", i), 16'h7FFF, t4_exp[i]);
`ifdef FIR_MAC_ARRAY_SAT_EN
    chk("t4_ovf", 64'(ovf), 64'(1));
`else
    chk("t4_ovf", 64'(ovf), 64'(0));
`endif

    // T5 write while busy is dropped; write+accept in one idle cycle uses the new value
    pulse_reset();
    write_coeff(0, 16'd4);
    din = 16'd1; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    chk("t5_coeff_ready_busy", 64'(coeff_ready), 64'(0));
    chk("t5_din_ready_busy", 64'(din_ready), 64'(0));
    coeff_wr = 1'b1; coeff_addr = 3'd0; coeff_data = 16'd20;
    tick();
    coeff_wr = 1'b0;
    wait_out("t5_busy", 2, lat, val);
    chk("t5_busy_dout", 64'(val), 64'(1));
    chk("t5_busy_lat", 64'(lat), 64'(6));
    send("t5_next", 16'd1, 16'd1);
    coeff_wr = 1'b1; coeff_addr = 3'd0; coeff_data = 16'd8;
    din = 16'd1; din_valid = 1'b1;
    tick();
    coeff_wr = 1'b0; din_valid = 1'b0;
    wait_out("t5_same", 1, lat, val);
    chk("t5_same_dout", 64'(val), 64'(2));

    // T6 reset at MAC cycle 2 discards the result and clears coefficients
    pulse_reset();
    write_coeff(0, 16'd4);
    din = 16'd1; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_din_ready", 64'(din_ready), 64'(1));
    chk("t6_coeff_ready", 64'(coeff_ready), 64'(1));
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (dout_valid) cnt++;
      tick();
    end
    chk("t6_no_valid", 64'(cnt), 64'(0));
    send("t6_coeff_cleared", 16'd5, 16'd0);

    // T6 clken low for 3 cycles mid-MAC stretches latency by 3
    write_coeff(0, 16'd4);
    din = 16'd7; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    tick();
    clken = 1'b0;
    repeat (3) tick();
    clken = 1'b1;
    wait_out("t6_clken", 5, lat, val);
    chk("t6_clken_lat", 64'(lat), 64'(9));
    chk("t6_clken_dout", 64'(val), 64'(7));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
